seg_scan_mux: RTL

//  Downstream display driver for the six-digit timer. Takes the six per-digit
//  8-bit segment patterns (sec0..hour1) and time-multiplexes them onto one

---
 rtl/seg_scan_mux.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_mux.sv
// Time-multiplexed six-digit segment driver with a blanking guard per digit slot.
// All digit patterns are captured together at each frame boundary so a mid-frame carry never tears the display.
module seg_scan_mux #(
    parameter int          DIGITS       = 6,
    parameter int          SCAN_DIV     = 1000,
    parameter int          BLANK_CYCLES = 2,
    parameter logic [7:0]  SEG_OFF      = 8'hFF,
    parameter bit          DIG_ACT_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [7:0]        sec0,
    input  logic [7:0]        sec1,
    input  logic [7:0]        min0,
    input  logic [7:0]        min1,
    input  logic [7:0]        hour0,
    input  logic [7:0]        hour1,
    output logic [7:0]        seg_out,
    output logic [DIGITS-1:0] dig_sel,
    output logic              frame_start
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0]     CNT_LAST       = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]     CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0]     IDX_LAST       = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] DIG_OFF        = {DIGITS{DIG_ACT_LOW}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_SHOW
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [7:0]        snap_q [DIGITS];
    logic [7:0]        snap_d [DIGITS];
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] dig_q, dig_d;
    logic [DIGITS-1:0] dig_onehot;
    logic              fs_q, fs_d;
    logic              snap_load;

    logic [7:0] pat_in [6];
    logic [7:0] fresh  [DIGITS];

    assign pat_in[0] = sec0;
    assign pat_in[1] = sec1;
    assign pat_in[2] = min0;
    assign pat_in[3] = min1;
    assign pat_in[4] = hour0;
    assign pat_in[5] = hour1;

    // Digits beyond the six physical inputs read as blank.
    for (genvar g = 0; g < DIGITS; g++) begin : g_fresh
        if (g < 6) begin : g_in
            assign fresh[g] = pat_in[g];
        end else begin : g_pad
            assign fresh[g] = SEG_OFF;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        snap_load = 1'b0;
        fs_d      = 1'b0;

        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = (BLANK_CYCLES == 0) ? S_SHOW : S_BLANK;
                    cnt_d     = '0;
                    idx_d     = '0;
                    snap_load = 1'b1;
                    fs_d      = 1'b1;
                end
                S_BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_BLANK_LAST) begin
                        state_d = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = (BLANK_CYCLES == 0) ? S_SHOW : S_BLANK;
                        if (idx_q == IDX_LAST) begin
                            idx_d     = '0;
                            snap_load = 1'b1;
                            fs_d      = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            snap_d[i] = snap_load ? fresh[i] : snap_q[i];
        end
    end

    // Outputs are computed from next-state so seg_out and dig_sel leave the same flops together.
    always_comb begin
        seg_d      = SEG_OFF;
        dig_d      = DIG_OFF;
        dig_onehot = DIGITS'(1) << idx_d;
        if (state_d == S_SHOW) begin
            seg_d = snap_d[idx_d];
            dig_d = DIG_ACT_LOW ? ~dig_onehot : dig_onehot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_OFF;
            dig_q   <= DIG_OFF;
            fs_q    <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                snap_q[i] <= SEG_OFF;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            fs_q    <= fs_d;
            for (int i = 0; i < DIGITS; i++) begin
                snap_q[i] <= snap_d[i];
            end
        end
    end

    assign seg_out     = seg_q;
    assign dig_sel     = dig_q;
    assign frame_start = fs_q;

endmodule
